// File: rtl/oh_par2ser.sv
`default_nettype none
// ============================================================================
//  Module   : oh_par2ser
//  Brief    : Parallel-to-serial converter. Accepts a PW-bit word through a
//             load/ready handshake and emits datasize+1 SW-bit words,
//             LSB-first or MSB-first, paced by the consumer's shift.
//  Option   : OH_PAR2SER_HOLD_EN -- when defined, dout keeps the last
//             transmitted word while idle instead of returning to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module oh_par2ser #(
  parameter int PW = 64,
  parameter int SW = 1,
  parameter int CW = $clog2(PW/SW)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [PW-1:0] din,
  input  logic          load,
  output logic          ready,
  input  logic          lsbfirst,
  input  logic [CW-1:0] datasize,
  input  logic          shift,
  output logic [SW-1:0] dout,
  output logic          access_out,
  output logic          lastout,
  output logic          busy
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam logic [CW-1:0] c_count_one = CW'(1);

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_shreg, w_shreg_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_order, w_order_nxt;

  logic          w_active;
  logic [SW-1:0] w_word;
  logic          w_accept;

  // Current serial word and handshake terms derived from registered state.
  assign w_active   = (r_state == S_ACTIVE);
  assign w_word     = r_order ? r_shreg[SW-1:0] : r_shreg[PW-1:PW-SW];
  assign lastout    = w_active && (r_count == '0);
  assign ready      = ~w_active | (lastout & shift);
  assign w_accept   = load & ready;
  assign access_out = w_active;
  assign busy       = w_active;

  // Next-state logic: a load accepted on the last word reloads directly so
  // back-to-back frames have no idle bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_count_nxt = r_count;
    w_order_nxt = r_order;
    if (w_accept) begin
      w_state_nxt = S_ACTIVE;
      w_shreg_nxt = din;
      w_count_nxt = datasize;
      w_order_nxt = lsbfirst;
    end else if (w_active && shift) begin
      if (lastout) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_shreg_nxt = r_order ? (r_shreg >> SW) : (r_shreg << SW);
        w_count_nxt = r_count - c_count_one;
      end
    end
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_count <= '0;
      r_order <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_count <= w_count_nxt;
      r_order <= w_order_nxt;
    end
  end

`ifdef OH_PAR2SER_HOLD_EN
  logic [SW-1:0] r_hold;

  // Remember the word on the line so an idle link does not toggle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_hold <= '0;
    end else if (w_active) begin
      r_hold <= w_word;
    end
  end

  assign dout = w_active ? w_word : r_hold;
`else
  assign dout = w_active ? w_word : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_oh_par2ser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oh_par2ser
//  Brief    : Directed self-checking bench for oh_par2ser with two instances
//             (PW=8/SW=1 and PW=16/SW=4) sharing one clock and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_oh_par2ser;

  logic clk;
  logic nreset;

  // PW=8, SW=1 instance
  logic [7:0] a_din;
  logic       a_load, a_ready, a_lsb, a_shift, a_dout, a_access, a_last, a_busy;
  logic [2:0] a_ds;

  // PW=16, SW=4 instance
  logic [15:0] b_din;
  logic        b_load, b_ready, b_lsb, b_shift, b_access, b_last, b_busy;
  logic [1:0]  b_ds;
  logic [3:0]  b_dout;

  int total = 0;
  int bad   = 0;

  oh_par2ser #(.PW(8), .SW(1)) u_a (
    .clk(clk), .nreset(nreset), .din(a_din), .load(a_load), .ready(a_ready),
    .lsbfirst(a_lsb), .datasize(a_ds), .shift(a_shift), .dout(a_dout),
    .access_out(a_access), .lastout(a_last), .busy(a_busy)
  );

  oh_par2ser #(.PW(16), .SW(4)) u_b (
    .clk(clk), .nreset(nreset), .din(b_din), .load(b_load), .ready(b_ready),
    .lsbfirst(b_lsb), .datasize(b_ds), .shift(b_shift), .dout(b_dout),
    .access_out(b_access), .lastout(b_last), .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  e8;
    logic [3:0]  e4 [4];
    logic [15:0] pat;
    int          idx;

    nreset = 1'b0;
    a_din = '0; a_load = 0; a_lsb = 0; a_ds = '0; a_shift = 0;
    b_din = '0; b_load = 0; b_lsb = 0; b_ds = '0; b_shift = 0;
    #2;
    chk("rst_a_busy",   64'(a_busy),   64'd0);
    chk("rst_a_access", 64'(a_access), 64'd0);
    chk("rst_a_last",   64'(a_last),   64'd0);
    chk("rst_a_dout",   64'(a_dout),   64'd0);
    chk("rst_a_ready",  64'(a_ready),  64'd1);
    chk("rst_b_dout",   64'(b_dout),   64'd0);
    @(negedge clk);
    nreset = 1'b1;

    // 8-bit, 0x1E LSB-first full word: 0,1,1,1,1,0,0,0
    e8 = 8'h1E;
    a_din = 8'h1E; a_lsb = 1; a_ds = 3'd7; a_load = 1; a_shift = 1;
    cyc();
    a_load = 0;
    for (int i = 0; i < 8; i++) begin
      chk("lsb8_dout", 64'(a_dout), 64'(e8[i]));
      chk("lsb8_last", 64'(a_last), 64'(i == 7));
      chk("lsb8_busy", 64'(a_busy), 64'd1);
      cyc();
    end
    chk("lsb8_idle_busy", 64'(a_busy), 64'd0);
    chk("lsb8_idle_dout", 64'(a_dout), 64'd0);

    // 8-bit, 0x1E MSB-first: 0,0,0,1,1,1,1,0
    a_lsb = 0; a_load = 1;
    cyc();
    a_load = 0;
    for (int i = 0; i < 8; i++) begin
      chk("msb8_dout", 64'(a_dout), 64'(e8[7-i]));
      chk("msb8_last", 64'(a_last), 64'(i == 7));
      cyc();
    end
    chk("msb8_idle_access", 64'(a_access), 64'd0);

    // 16-bit nibbles, 0x1234 LSB-first, 4 words: 4,3,2,1
    e4[0] = 4'h4; e4[1] = 4'h3; e4[2] = 4'h2; e4[3] = 4'h1;
    b_din = 16'h1234; b_lsb = 1; b_ds = 2'd3; b_load = 1; b_shift = 1;
    cyc();
    b_load = 0;
    for (int i = 0; i < 4; i++) begin
      chk("lsb16_dout", 64'(b_dout), 64'(e4[i]));
      chk("lsb16_last", 64'(b_last), 64'(i == 3));
      cyc();
    end
    chk("lsb16_idle_busy", 64'(b_busy), 64'd0);

    // 16-bit, 0x1234 MSB-first, 2 words: 1,2 then idle
    b_lsb = 0; b_ds = 2'd1; b_load = 1;
    cyc();
    b_load = 0;
    chk("msb16_w0", 64'(b_dout), 64'h1);
    chk("msb16_l0", 64'(b_last), 64'd0);
    cyc();
    chk("msb16_w1", 64'(b_dout), 64'h2);
    chk("msb16_l1", 64'(b_last), 64'd1);
    cyc();
    chk("msb16_idle_busy", 64'(b_busy), 64'd0);
`ifdef OH_PAR2SER_HOLD_EN
    chk("msb16_idle_dout", 64'(b_dout), 64'h2);
`else
    chk("msb16_idle_dout", 64'(b_dout), 64'h0);
`endif

    // Stalled 0x1234 LSB-first with irregular shift: sequence unchanged
    b_lsb = 1; b_ds = 2'd3; b_load = 1; b_shift = 0;
    cyc();
    b_load = 0;
    pat = 16'b1011_0010_1100_1010;
    idx = 0;
    for (int c = 0; c < 16 && idx < 4; c++) begin
      b_shift = pat[c];
      chk("stall_dout", 64'(b_dout), 64'(e4[idx]));
      chk("stall_last", 64'(b_last), 64'(idx == 3));
      cyc();
      if (pat[c]) idx++;
    end
    chk("stall_words_done", 64'(idx), 64'd4);
    chk("stall_idle_busy", 64'(b_busy), 64'd0);

    // Single-word frame (datasize=0): 0xABCD MSB-first -> A
    b_din = 16'hABCD; b_lsb = 0; b_ds = 2'd0; b_load = 1; b_shift = 1;
    cyc();
    b_load = 0;
    chk("one_dout", 64'(b_dout), 64'hA);
    chk("one_last", 64'(b_last), 64'd1);
    cyc();
    chk("one_idle_busy", 64'(b_busy), 64'd0);
`ifdef OH_PAR2SER_HOLD_EN
    chk("one_idle_dout", 64'(b_dout), 64'hA);
`else
    chk("one_idle_dout", 64'(b_dout), 64'h0);
`endif

    // Back-to-back: 0xA5 MSB 2 words (1,0), next load held from word 0,
    // accepted only on the last word; then 0x3C LSB 3 words (0,0,1).
    a_din = 8'hA5; a_lsb = 0; a_ds = 3'd1; a_load = 1; a_shift = 1;
    cyc();
    a_din = 8'h3C; a_lsb = 1; a_ds = 3'd2;
    #1;
    chk("b2b_ready_mid", 64'(a_ready), 64'd0);
    chk("b2b_w0", 64'(a_dout), 64'd1);
    chk("b2b_l0", 64'(a_last), 64'd0);
    cyc();
    #1;
    chk("b2b_w1", 64'(a_dout), 64'd0);
    chk("b2b_l1", 64'(a_last), 64'd1);
    chk("b2b_ready_last", 64'(a_ready), 64'd1);
    cyc();
    a_load = 0;
    chk("b2b_nobubble", 64'(a_busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_f2_dout", 64'(a_dout), 64'(i == 2));
      chk("b2b_f2_last", 64'(a_last), 64'(i == 2));
      cyc();
    end
    chk("b2b_idle_busy", 64'(a_busy), 64'd0);

    // Reset mid-frame: 0x96 LSB-first (0,1,1,0,...) aborted after 3 words
    e8 = 8'h96;
    a_din = 8'h96; a_lsb = 1; a_ds = 3'd7; a_load = 1; a_shift = 1;
    cyc();
    a_load = 0;
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_dout", 64'(a_dout), 64'(e8[i]));
      cyc();
    end
    chk("rstmid_w3_busy", 64'(a_busy), 64'd1);
    nreset = 1'b0;
    #1;
    chk("rstmid_access", 64'(a_access), 64'd0);
    chk("rstmid_busy",   64'(a_busy),   64'd0);
    chk("rstmid_dout",   64'(a_dout),   64'd0);
    @(negedge clk);
    nreset = 1'b1;
    cyc();
    cyc();
    chk("rstpost_access", 64'(a_access), 64'd0);
    chk("rstpost_dout",   64'(a_dout),   64'd0);
    chk("rstpost_ready",  64'(a_ready),  64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oh_par2ser.md
Name: oh_par2ser

Overview:
Parallel-to-serial converter: accepts a PW-bit word through a load/ready handshake and emits it as a sequence of SW-bit serial words, LSB-first or MSB-first. It is the transmit-side counterpart of the serial-to-parallel converter and feeds serial links, SPI/IO shifters and similar narrow paths. A programmable transfer length supports partial words. Consumer flow control is through shift.

Parameters:
PW, 64, parallel word width; PW/SW must be a power of 2.
SW, 1, serial word width.
CW, $clog2(PW/SW), counter width.

Ports:
clk  input  1  clock.
nreset  input  1  asynchronous active-low reset.
din  input  PW  parallel data.
load  input  1  load request, valid with din/lsbfirst/datasize.
ready  output  1  load will be accepted this cycle.
lsbfirst  input  1  1 = LSB-first order; sampled at load.
datasize  input  CW  number of serial words to send minus 1; sampled at load.
shift  input  1  consumer takes current dout and advances.
dout  output  SW  serial data.
access_out  output  1  dout is valid.
lastout  output  1  dout is the final word of the frame.
busy  output  1  frame in progress (same as access_out).

Behaviour:
- Reset (nreset low, async): shreg=0, count=0, order=0, busy=0, access_out=0, lastout=0, dout=0. Reset mid-frame aborts the frame; no words are emitted after release until a new load.
- States:
  - IDLE (busy=0).
  - ACTIVE (busy=1).
- ready = ~busy | (lastout & shift).
- Accept = load & ready. On accept:
  - shreg<=din, count<=datasize, order<=lsbfirst, state<=ACTIVE.
  - First word is on dout the next cycle (latency 1).
  - Load while not ready is ignored; upstream holds load and din.
- ACTIVE:
  - dout = order ? shreg[SW-1:0] : shreg[PW-1:PW-SW].
  - lastout = (count==0).
- ACTIVE & shift & ~lastout: shreg shifts by SW toward the output end, zero-filling the vacated bits; count decrements.
- ACTIVE & shift & lastout:
  - With accept in the same cycle: reload; the next frame follows with no bubble.
  - Otherwise: go to IDLE.
- ACTIVE & ~shift: all state holds; dout stable.
- shift in IDLE: no effect.
- lsbfirst or datasize changes mid-frame: ignored; values are latched at load.
- datasize=0: a single-word frame; lastout=1 on the first word.
- datasize=PW/SW-1: the full word is sent. There is no wrap; count never underflows.
- Words sent per frame = datasize+1, exactly.

Optional Feature:
OH_PAR2SER_HOLD_EN
- Not defined: dout is forced to 0 whenever access_out=0.
- Defined: in IDLE, dout holds the last transmitted word; only reset clears it. This reduces output toggling on idle links.
- access_out/lastout/ready behaviour is identical in both builds.

Test Plan:
- PW=8,SW=1: load din=0x1E, lsbfirst=1, datasize=7, shift held 1 -> dout 0,1,1,1,1,0,0,0 on the 8 cycles after load; lastout on the 8th word only; busy=0 the following cycle.
- Same with lsbfirst=0 -> 0,0,0,1,1,1,1,0.
- PW=16,SW=4: load 0x1234, lsbfirst=1, datasize=3 -> 4,3,2,1; with lsbfirst=0, datasize=1 -> 1,2 then IDLE.
- Stall and back-to-back:
  - Random shift gaps -> dout holds during gaps and the sequence is unchanged.
  - load asserted during the final word with shift=1 -> ready=1 and the next frame's first word follows with no idle cycle.
  - load held mid-frame -> ignored until the last word.
- Reset mid-frame: nreset pulsed low after 3 words -> access_out/busy/dout drop to 0 immediately (async); no further words until a new load. Without OH_PAR2SER_HOLD_EN, dout=0 in IDLE; with it, dout keeps the last word.
